divider_unit: RTL and testbench
===============================

Name: divider_unit

Overview:
- Multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU) for the RV32I core.
- Consumes operands from register_file read_data_1/read_data_2.
- Writes its result back through register_file port 3: drives addr_3, write_data_3 and write_enable_3 directly.
- Radix-2 restoring division, one quotient bit per clock; the pipeline stalls on busy.

Parameters:
- OperandSize, 32, datapath width; matches rv32i_defs::OperandSize.
- RegisterSize, 5, register address width; matches rv32i_defs::RegisterSize.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- rs1_data  input  OperandSize  dividend, from read_data_1.
- rs2_data  input  OperandSize  divisor, from read_data_2.
- rd_addr  input  RegisterSize  destination register.
- kill  input  1  abort in-flight operation (pipeline flush).
- busy  output  1  high in BUSY and DONE.
- done  output  1  one-cycle completion pulse.
- addr_3  output  RegisterSize  to register_file addr_3.
- write_data_3  output  OperandSize  to register_file write_data_3.
- write_enable_3  output  1  to register_file write_enable_3.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, done, write_enable_3, addr_3, write_data_3 and all internal registers = 0. Takes effect immediately mid-operation; no write issued.
- States: IDLE, BUSY, DONE.
- IDLE, start=1 at edge E0:
  - Latch op, rd_addr and operands.
  - Divisor==0 or signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): result computed at E0, go to DONE.
  - Otherwise: load |dividend| and |divisor| (absolute value only for DIV/REM; raw for DIVU/REMU), iteration count=0, go to BUSY.
- BUSY: one shift/subtract iteration per edge; after the 32nd iteration (edge E32), apply sign fix-up, register the result and go to DONE.
- DONE: lasts exactly one cycle, then IDLE at the next edge.
  - done=1; addr_3=latched rd; write_data_3=result.
  - write_enable_3=1 unless latched rd==0 (then 0; done still pulses).
  - Register file commits at the edge leaving DONE.
- Latency (start accepted at E0):
  - Normal: DONE occupies the cycle after E32; 33 cycles from E0 to write.
  - Special cases: DONE occupies the cycle after E0.
- busy asserted from the cycle after E0 through DONE inclusive.
- start while busy is ignored; operands are not re-sampled.
- kill=1 in BUSY or DONE: next edge goes to IDLE, done=0, write_enable_3=0. kill in DONE suppresses the write combinationally in that cycle. kill in IDLE has no effect; kill and start both high in IDLE are ignored.
- Sign rules (DIV/REM):
  - Quotient negated if operand signs differ.
  - Remainder takes the sign of the dividend.
  - Arithmetic is modulo 2^OperandSize.
- Special results:
  - Divide by zero: quotient = all ones (DIV and DIVU); remainder = dividend.
  - Overflow: quotient = 0x80000000, remainder = 0.
- Outputs addr_3 and write_data_3 are 0 outside DONE.
- A new start may be accepted in the cycle after DONE (back-to-back issue).

Test Plan:
- DIVU 100/7, rd=5 -> busy high 33 cycles; single DONE cycle with write_enable_3=1, addr_3=5, write_data_3=14; register x5 reads 14 afterward.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; REMU 0xFFFFFFF9/2 -> 1.
- DIV 0x12345678/0 -> DONE in the cycle after E0 with 0xFFFFFFFF; REMU 0x12345678/0 -> 0x12345678.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000 one cycle after E0; REM same operands -> 0.
- DIVU 1000/3: kill at cycle 10 -> IDLE, no write_enable_3; start pulse at cycle 5 ignored; fresh DIVU 9/3 afterward returns 3 in 33 cycles.
- rst=0 at cycle 15 of an op -> all outputs 0 immediately, no write; DIVU 8/2 with rd=0 -> done pulses, write_enable_3 stays 0.

Source files
------------

// File: rtl/divider_unit_if.sv
// Request/writeback bundle between the issuing pipeline and the divide unit.
// Latency: n/a (wires only).
// Backpressure: the issuer must hold off while busy is high; start is ignored otherwise.
//
// Ports (signals):
//   start, op, rs1_data, rs2_data, rd_addr, kill : issuer -> divider
//   busy, done, addr_3, write_data_3, write_enable_3 : divider -> issuer / register_file port 3
interface divider_unit_if #(
  parameter int OperandSize  = 32,
  parameter int RegisterSize = 5
);
  logic                    start;
  logic [1:0]              op;
  logic [OperandSize-1:0]  rs1_data;
  logic [OperandSize-1:0]  rs2_data;
  logic [RegisterSize-1:0] rd_addr;
  logic                    kill;
  logic                    busy;
  logic                    done;
  logic [RegisterSize-1:0] addr_3;
  logic [OperandSize-1:0]  write_data_3;
  logic                    write_enable_3;

  modport master (
    output start, op, rs1_data, rs2_data, rd_addr, kill,
    input  busy, done, addr_3, write_data_3, write_enable_3
  );

  modport slave (
    input  start, op, rs1_data, rs2_data, rd_addr, kill,
    output busy, done, addr_3, write_data_3, write_enable_3
  );
endinterface

// File: rtl/divider_unit.sv
// RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring division, one quotient bit per clock.
// Latency: 33 cycles start-to-write (DONE after 32 iterations); 1 cycle for divide-by-zero/overflow.
// Backpressure: busy high from the cycle after acceptance through DONE; start ignored meanwhile.
//
// Ports: clk, rst (async, active-low); bus (slave modport of divider_unit_if):
//   start/op/rs1_data/rs2_data/rd_addr/kill in; busy/done and register_file port 3
//   (addr_3, write_data_3, write_enable_3) out.
module divider_unit #(
  parameter int OperandSize  = 32,
  parameter int RegisterSize = 5
) (
  input  logic          clk,
  input  logic          rst,
  divider_unit_if.slave bus
);
  localparam int W    = OperandSize;
  localparam int CntW = $clog2(OperandSize);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state, state_next;
  logic                    is_rem_q;
  logic [RegisterSize-1:0] rd_q;
  logic [W-1:0]            quo_q;     // dividend shifts out, quotient shifts in
  logic [W-1:0]            rem_q;
  logic [W-1:0]            dvs_q;
  logic [W-1:0]            result_q;
  logic                    neg_q_q;   // negate quotient at the end
  logic                    neg_r_q;   // negate remainder at the end
  logic [CntW-1:0]         count;

  // Operand preparation at acceptance
  logic         is_signed, a_neg, b_neg, div_zero, overflow, special, accept;
  logic [W-1:0] a_abs, b_abs, special_result;

  assign is_signed = ~bus.op[0];
  assign a_neg     = is_signed & bus.rs1_data[W-1];
  assign b_neg     = is_signed & bus.rs2_data[W-1];
  assign a_abs     = a_neg ? -bus.rs1_data : bus.rs1_data;
  assign b_abs     = b_neg ? -bus.rs2_data : bus.rs2_data;
  assign div_zero  = (bus.rs2_data == '0);
  assign overflow  = is_signed && (bus.rs1_data == {1'b1, {(W-1){1'b0}}}) &&
                     (bus.rs2_data == '1);
  assign special   = div_zero | overflow;
  assign accept    = (state == IDLE) && bus.start && !bus.kill;

  always_comb begin
    special_result = '0;
    if (div_zero)
      special_result = bus.op[1] ? bus.rs1_data : '1;
    else if (overflow)
      special_result = bus.op[1] ? '0 : {1'b1, {(W-1){1'b0}}};
  end

  // One restoring step: shift the next dividend bit into the partial remainder
  // and subtract when it fits. rem_q < divisor, so rem_shift needs one extra bit.
  logic [W:0]   rem_shift, diff;
  logic         take, last;
  logic [W-1:0] rem_nxt, quo_nxt, q_fin, r_fin;

  assign rem_shift = {rem_q, quo_q[W-1]};
  assign diff      = rem_shift - {1'b0, dvs_q};
  assign take      = ~diff[W];
  assign rem_nxt   = take ? diff[W-1:0] : rem_shift[W-1:0];
  assign quo_nxt   = {quo_q[W-2:0], take};
  assign last      = (count == CntW'(OperandSize - 1));
  assign q_fin     = neg_q_q ? -quo_nxt : quo_nxt;
  assign r_fin     = neg_r_q ? -rem_nxt : rem_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = special ? DONE : BUSY;
      BUSY: begin
        if (bus.kill)  state_next = IDLE;
        else if (last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy           = (state != IDLE);
    bus.done           = (state == DONE) && !bus.kill;
    bus.write_enable_3 = bus.done && (rd_q != '0);
    bus.addr_3         = '0;
    bus.write_data_3   = '0;
    if (state == DONE) begin
      bus.addr_3       = rd_q;
      bus.write_data_3 = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_rem_q <= 1'b0;
      rd_q     <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      count    <= '0;
    end else if (accept) begin
      is_rem_q <= bus.op[1];
      rd_q     <= bus.rd_addr;
      quo_q    <= a_abs;
      rem_q    <= '0;
      dvs_q    <= b_abs;
      neg_q_q  <= a_neg ^ b_neg;
      neg_r_q  <= a_neg;
      count    <= '0;
      if (special) result_q <= special_result;
    end else if (state == BUSY && !bus.kill) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
      count <= count + CntW'(1);
      if (last) result_q <= is_rem_q ? r_fin : q_fin;
    end
  end
endmodule

// File: tb/tb_divider_unit.sv
// Directed bench for divider_unit: vector table plus kill, reset, start-while-busy
// and rd=0 sequences. A small register-file model records port-3 writes.
module tb_divider_unit;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  divider_unit_if #(.OperandSize(32), .RegisterSize(5)) bus ();

  divider_unit #(.OperandSize(32), .RegisterSize(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] regs [32] = '{default: 32'h0};
  int          we_cnt = 0;
  always @(posedge clk) begin
    if (bus.write_enable_3) begin
      regs[bus.addr_3] <= bus.write_data_3;
      we_cnt           <= we_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge (E0).
  // Returns at the negedge of the cycle after E0.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_addr  = rd;
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Follows an accepted op to its DONE cycle. poke>0 raises start with other
  // operands for one cycle at that cycle count, which must be ignored.
  task automatic wait_done(input string name, input int exp_lat, input logic [31:0] exp_data,
                           input logic [4:0] exp_rd, input logic exp_we, input int poke);
    int n      = 1;
    int busy_n = 0;
    int bad    = 0;
    bit seen   = 1'b0;
    while (n <= 60 && !seen) begin
      if (n == poke + 1) bus.start = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        seen = 1'b1;
        check({name, " latency"}, n, exp_lat);
        check({name, " data"}, bus.write_data_3, exp_data);
        check({name, " addr"}, {27'h0, bus.addr_3}, {27'h0, exp_rd});
        check({name, " we"}, {31'h0, bus.write_enable_3}, {31'h0, exp_we});
      end else begin
        if (bus.write_enable_3 || bus.addr_3 != 5'd0 || bus.write_data_3 != 32'h0) bad++;
        if (n == poke) begin
          bus.start    = 1'b1;
          bus.op       = OP_DIVU;
          bus.rs1_data = 32'd50;
          bus.rs2_data = 32'd5;
          bus.rd_addr  = 5'd1;
        end
        @(negedge clk);
        n++;
      end
    end
    bus.start = 1'b0;
    if (!seen) check({name, " done timeout"}, 32'd0, 32'd1);
    check({name, " busy cycles"}, busy_n, exp_lat);
    check({name, " outputs outside DONE"}, bad, 0);
    @(negedge clk);
    check({name, " idle after done"}, {30'h0, bus.busy, bus.done}, 32'h0);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int cnt0;
    int done_seen;

    vecs[0]  = '{"divu 100/7",       OP_DIVU, 32'd100,      32'd7,        5'd5,  32'd14,       33};
    vecs[1]  = '{"div -7/2",         OP_DIV,  32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD, 33};
    vecs[2]  = '{"rem -7/2",         OP_REM,  32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF, 33};
    vecs[3]  = '{"remu fff9/2",      OP_REMU, 32'hFFFFFFF9, 32'd2,        5'd8,  32'd1,        33};
    vecs[4]  = '{"div by zero",      OP_DIV,  32'h12345678, 32'd0,        5'd13, 32'hFFFFFFFF, 1};
    vecs[5]  = '{"remu by zero",     OP_REMU, 32'h12345678, 32'd0,        5'd14, 32'h12345678, 1};
    vecs[6]  = '{"div overflow",     OP_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1};
    vecs[7]  = '{"rem overflow",     OP_REM,  32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000, 1};
    vecs[8]  = '{"divu by zero",     OP_DIVU, 32'h12345678, 32'd0,        5'd17, 32'hFFFFFFFF, 1};
    vecs[9]  = '{"rem by zero",      OP_REM,  32'h12345678, 32'd0,        5'd18, 32'h12345678, 1};
    vecs[10] = '{"div 7/-2",         OP_DIV,  32'd7,        32'hFFFFFFFE, 5'd19, 32'hFFFFFFFD, 33};
    vecs[11] = '{"rem 7/-2",         OP_REM,  32'd7,        32'hFFFFFFFE, 5'd20, 32'd1,        33};
    vecs[12] = '{"div -8/-2",        OP_DIV,  32'hFFFFFFF8, 32'hFFFFFFFE, 5'd21, 32'd4,        33};
    vecs[13] = '{"remu max/10000",   OP_REMU, 32'hFFFFFFFF, 32'h00010000, 5'd22, 32'h0000FFFF, 33};
    vecs[14] = '{"div min/1",        OP_DIV,  32'h80000000, 32'd1,        5'd23, 32'h80000000, 33};
    vecs[15] = '{"rem min/3",        OP_REM,  32'h80000000, 32'd3,        5'd24, 32'hFFFFFFFE, 33};

    bus.start    = 1'b0;
    bus.op       = 2'b00;
    bus.rs1_data = 32'h0;
    bus.rs2_data = 32'h0;
    bus.rd_addr  = 5'd0;
    bus.kill     = 1'b0;
    rst          = 1'b0;
    repeat (2) @(negedge clk);
    check("reset outputs", {bus.busy, bus.done, bus.write_enable_3, bus.addr_3, bus.write_data_3[23:0]},
          32'h0);
    check("reset data", bus.write_data_3, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Back-to-back: each issue lands in the IDLE cycle right after DONE.
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
      wait_done(vecs[i].name, vecs[i].lat, vecs[i].exp, vecs[i].rd, 1'b1, 0);
    end
    check("regfile x5", regs[5], 32'd14);
    check("regfile x24", regs[24], 32'hFFFFFFFE);

    // start while busy is ignored; the original operands complete.
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd11);
    wait_done("divu 1000/3 with stray start", 33, 32'd333, 5'd11, 1'b1, 5);

    // kill and start together in IDLE does nothing.
    bus.kill  = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.kill  = 1'b0;
    bus.start = 1'b0;
    check("kill+start idle", {31'h0, bus.busy}, 32'h0);

    // Kill mid-operation: start pulse at cycle 5 ignored, kill at cycle 10.
    cnt0      = we_cnt;
    done_seen = 0;
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd9);
    for (int n = 1; n < 10; n++) begin
      bus.start = (n == 5);
      if (bus.done) done_seen++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("busy before kill", {31'h0, bus.busy}, 32'h1);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    check("busy after kill", {31'h0, bus.busy}, 32'h0);
    for (int n = 0; n < 40; n++) begin
      if (bus.done || bus.busy) done_seen++;
      @(negedge clk);
    end
    check("no done after kill", done_seen, 0);
    check("no write after kill", we_cnt - cnt0, 0);
    check("x9 untouched", regs[9], 32'h0);
    issue(OP_DIVU, 32'd9, 32'd3, 5'd10);
    wait_done("divu 9/3 after kill", 33, 32'd3, 5'd10, 1'b1, 0);

    // Asynchronous reset mid-operation.
    cnt0 = we_cnt;
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd12);
    repeat (14) @(negedge clk);
    check("busy before reset", {31'h0, bus.busy}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("outputs in reset", {bus.busy, bus.done, bus.write_enable_3, bus.addr_3, 24'h0},
          32'h0);
    check("data in reset", bus.write_data_3, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("no write after reset", we_cnt - cnt0, 0);
    check("x12 untouched", regs[12], 32'h0);

    // rd = 0: done pulses, no register write.
    cnt0 = we_cnt;
    issue(OP_DIVU, 32'd8, 32'd2, 5'd0);
    wait_done("divu 8/2 rd0", 33, 32'd4, 5'd0, 1'b0, 0);
    check("no write for rd0", we_cnt - cnt0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
